// File: rtl/pulse_det_pkg.sv
// Shared types and constants for the pulse width detector: per-channel FSM
// states and the counter saturation value.
package pulse_det_pkg;

  typedef enum logic [1:0] {
    LOW  = 2'd0,
    HIGH = 2'd1,
    OVER = 2'd2
  } ch_state_e;

  // All-ones value of a cnt_w-bit counter; the counter parks here once a pulse is too long to count.
  function automatic int unsigned sat_count(input int unsigned cnt_w);
    return (32'd1 << cnt_w) - 32'd1;
  endfunction

endpackage

// File: rtl/pulse_width_detector_if.sv
// Bus bundle for the pulse width detector.
// Raw channel levels and thresholds go in; edge and classification strobes come out.
interface pulse_width_detector_if #(
  parameter int N_CH  = 4,
  parameter int CNT_W = 8
);

  logic [N_CH-1:0]       a;
  logic [N_CH-1:0]       polarity;
  logic [CNT_W-1:0]      min_w;
  logic [CNT_W-1:0]      max_w;
  logic [N_CH-1:0]       rise;
  logic [N_CH-1:0]       fall;
  logic [N_CH-1:0]       pulse_ok;
  logic [N_CH-1:0]       pulse_short;
  logic [N_CH-1:0]       pulse_long;
  logic [N_CH*CNT_W-1:0] last_width;

  modport master (
    output a, polarity, min_w, max_w,
    input  rise, fall, pulse_ok, pulse_short, pulse_long, last_width
  );

  modport slave (
    input  a, polarity, min_w, max_w,
    output rise, fall, pulse_ok, pulse_short, pulse_long, last_width
  );

endinterface

// File: rtl/pulse_det_channel.sv
// One detector channel: edge detection, a LOW/HIGH/OVER width-counting FSM,
// and a classifier that grades each pulse as it ends.
module pulse_det_channel
  import pulse_det_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             a,
  input  logic             polarity,
  input  logic [CNT_W-1:0] min_w,
  input  logic [CNT_W-1:0] max_w,
  output logic             rise,
  output logic             fall,
  output logic             pulse_ok,
  output logic             pulse_short,
  output logic             pulse_long,
  output logic [CNT_W-1:0] last_width
);

  localparam logic [CNT_W-1:0] SAT = CNT_W'(sat_count(CNT_W));

  ch_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] last_width_q, last_width_d;
  logic             b_q, b_d;

  logic             b;
  logic             b_r;
  logic [CNT_W-1:0] min_eff;

  assign b = a ^ polarity;
  // While rst is high the outputs behave as if the registered level were already cleared.
  assign b_r = b_q & ~rst;
  assign min_eff = (min_w == '0) ? CNT_W'(1) : min_w;
  assign last_width = last_width_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= LOW;
      cnt_q        <= '0;
      last_width_q <= '0;
      b_q          <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      last_width_q <= last_width_d;
      b_q          <= b_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    b_d          = b;
    last_width_d = fall ? cnt_q : last_width_q;
    case (state_q)
      LOW: begin
        if (b) begin
          state_d = HIGH;
          cnt_d   = CNT_W'(1);
        end
      end
      HIGH: begin
        if (b) begin
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == SAT - CNT_W'(1)) state_d = OVER;
        end else begin
          state_d = LOW;
        end
      end
      OVER: begin
        if (!b) state_d = LOW;
      end
      default: state_d = LOW;
    endcase
  end

  always_comb begin
    rise        = b & ~b_r;
    fall        = ~b & b_r;
    pulse_ok    = 1'b0;
    pulse_short = 1'b0;
    pulse_long  = 1'b0;
    if (fall) begin
      if (state_q == OVER)       pulse_long  = 1'b1;
      else if (cnt_q < min_eff)  pulse_short = 1'b1;
      else if (cnt_q > max_w)    pulse_long  = 1'b1;
      else                       pulse_ok    = 1'b1;
    end
  end

endmodule

// File: rtl/pulse_width_detector.sv
// Multi-channel pulse width detector: N_CH independent channels sharing
// the min/max width thresholds.
module pulse_width_detector
  import pulse_det_pkg::*;
#(
  parameter int N_CH  = 4,
  parameter int CNT_W = 8
) (
  input logic                 clk,
  input logic                 rst,
  pulse_width_detector_if.slave bus
);

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    pulse_det_channel #(
      .CNT_W(CNT_W)
    ) u_ch (
      .clk        (clk),
      .rst        (rst),
      .a          (bus.a[i]),
      .polarity   (bus.polarity[i]),
      .min_w      (bus.min_w),
      .max_w      (bus.max_w),
      .rise       (bus.rise[i]),
      .fall       (bus.fall[i]),
      .pulse_ok   (bus.pulse_ok[i]),
      .pulse_short(bus.pulse_short[i]),
      .pulse_long (bus.pulse_long[i]),
      .last_width (bus.last_width[i*CNT_W +: CNT_W])
    );
  end

endmodule
